// File: rtl/io_hub_pkg.sv
// io_hub_pkg: constants and FSM state type shared by the debug I/O hub encode/decode blocks
package io_hub_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int WORD_BYTES = 4;
  localparam int DEFAULT_CLK_DIV = 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serializes one 8N1 byte (STOP_BITS stop bits); start may coincide with done
module uart_tx_byte import io_hub_pkg::*; #(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx,
  output state_t     state
);
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  logic [15:0] baud;
  logic [2:0] bit_cnt;
  logic stop_cnt;
  logic [7:0] sr;
  logic tick;
  assign tick = baud == LAST;
  assign done = state == STOP && tick && stop_cnt == 1'(STOP_BITS - 1);
  // start outranks everything so the next frame begins on the cycle the previous one ends
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      stop_cnt <= '0;
      sr <= '0;
      tx <= 1'b1;
    end else if (start) begin
      state <= START;
      baud <= '0;
      bit_cnt <= '0;
      stop_cnt <= '0;
      sr <= data;
      tx <= 1'b0;
    end else if (state != IDLE) begin
      baud <= tick ? '0 : baud + 1'b1;
      if (tick)
        case (state)
          START: begin
            state <= DATA;
            tx <= sr[0];
            sr <= sr >> 1;
          end
          DATA:
            if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
              state <= STOP;
              tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx <= sr[0];
              sr <= sr >> 1;
            end
          default:
            if (done) begin
              state <= IDLE;
              bit_cnt <= '0;
              stop_cnt <= '0;
            end else stop_cnt <= stop_cnt + 1'b1;
        endcase
    end
endmodule

// File: rtl/encode.sv
// encode: accepts a 32-bit word and transmits it LSB byte first as four back-to-back UART frames
module encode import io_hub_pkg::*; #(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        tx,
  output logic        busy
);
  logic [31:0] word;
  logic [1:0] byte_cnt;
  logic accept, done, start;
  logic [7:0] data;
  state_t state;
  assign din_ready = state == IDLE;
  assign busy = !din_ready;
  assign accept = din_valid && din_ready;
  assign start = accept || (done && byte_cnt != 2'(WORD_BYTES - 1));
  // word[15:8] is always the byte after the one currently on the line
  assign data = accept ? din[7:0] : word[15:8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      word <= din;
      byte_cnt <= '0;
    end else if (done) begin
      word <= word >> UART_DATA_BITS;
      byte_cnt <= byte_cnt + 1'b1;
    end
  uart_tx_byte #(.CLK_DIV(CLK_DIV), .STOP_BITS(STOP_BITS)) u_byte (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data(data),
    .done(done),
    .tx(tx),
    .state(state)
  );
endmodule
